// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and defaults for the game sequencer
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int SCORE_DIGITS     = 3;
  localparam int SPEED_W          = 4;
  localparam int DEF_TICK_CYCLES  = 2000000;
  localparam int DEF_PASS_LIMIT   = 12;
  localparam int DEF_SPEED_MAX    = 15;
  localparam int DEF_DEAD_CYCLES  = 50000000;

  // Counter width that stays legal when the count collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// rtl/bcd_counter3.sv - three-digit BCD score counter with clear and 999->000 wrap
module bcd_counter3
  import game_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [4*SCORE_DIGITS-1:0] value
);

  logic [4*SCORE_DIGITS-1:0] value_q, value_d;
  logic                      carry;

  always_comb begin
    value_d = value_q;
    carry   = inc;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          value_d[4*i +: 4] = 4'd0;
        end else begin
          value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clr) begin
      value_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game state machine, motion tick, score, speed and animation
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int PASS_LIMIT  = DEF_PASS_LIMIT,
  parameter int SPEED_MAX   = DEF_SPEED_MAX,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               collision,
  input  logic               obstacle_wrap,
  output logic [1:0]         state,
  output logic               motion_tick,
  output logic [SPEED_W-1:0] speed,
  output logic [11:0]        score_bcd,
  output logic [1:0]         anim_phase,
  output logic               game_over
);

  localparam int TICK_W = cnt_width(TICK_CYCLES);
  localparam int PASS_W = cnt_width(PASS_LIMIT + 1);
  localparam int DEAD_W = cnt_width(DEAD_CYCLES);

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [PASS_W-1:0]  PASS_TOP  = PASS_W'(PASS_LIMIT);
  localparam logic [SPEED_W-1:0] SPEED_TOP = SPEED_W'(SPEED_MAX);
  localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  state_e              state_q, state_d;
  logic                start_q, start_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [DEAD_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [1:0]          anim_q, anim_d;
  logic                motion_tick_q, motion_tick_d;
  logic                game_over_q, game_over_d;
  logic                start_edge;
  logic                score_clr;
  logic                score_inc;
  logic [PASS_W-1:0]   pass_next;

  assign start_edge = start_btn & ~start_q;
  assign pass_next  = pass_cnt_q + PASS_W'(1);

  // The tick event is decided at the edge closing the last count of a period, so a
  // collision seen in that same cycle can still cancel it; motion_tick is its registered pulse.
  always_comb begin
    state_d       = state_q;
    start_d       = start_btn;
    tick_cnt_d    = tick_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    dwell_cnt_d   = dwell_cnt_q;
    speed_d       = speed_q;
    anim_d        = anim_q;
    motion_tick_d = 1'b0;
    score_clr     = 1'b0;
    score_inc     = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_RUN;
          tick_cnt_d  = '0;
          pass_cnt_d  = '0;
          dwell_cnt_d = '0;
          speed_d     = SPEED_W'(1);
          anim_d      = 2'd0;
          score_clr   = 1'b1;
        end
      end

      ST_RUN: begin
        if (collision) begin
          state_d     = ST_DYING;
          dwell_cnt_d = '0;
        end else begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d    = '0;
            motion_tick_d = 1'b1;
            score_inc     = 1'b1;
            anim_d        = anim_q + 2'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end

          if (obstacle_wrap) begin
            if (pass_next == PASS_TOP) begin
              pass_cnt_d = '0;
              if (speed_q < SPEED_TOP) begin
                speed_d = speed_q + SPEED_W'(1);
              end
            end else begin
              pass_cnt_d = pass_next;
            end
          end
        end
      end

      ST_DYING: begin
        if (dwell_cnt_q == DEAD_LAST) begin
          state_d = ST_OVER;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DEAD_W'(1);
        end
      end
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      tick_cnt_q    <= '0;
      pass_cnt_q    <= '0;
      dwell_cnt_q   <= '0;
      speed_q       <= SPEED_W'(1);
      anim_q        <= 2'd0;
      motion_tick_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      tick_cnt_q    <= tick_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      speed_q       <= speed_d;
      anim_q        <= anim_d;
      motion_tick_q <= motion_tick_d;
      game_over_q   <= game_over_d;
    end
  end

  bcd_counter3 u_score (
    .clk   (clk),
    .rst   (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score_bcd)
  );

  assign state       = state_q;
  assign motion_tick = motion_tick_q;
  assign speed       = speed_q;
  assign anim_phase  = anim_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer against an integer game model
module tb_game_sequencer;

  localparam int TICK = 4;
  localparam int DEAD = 8;
  localparam int PASS = 12;
  localparam int SMAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        collision;
  logic        obstacle_wrap;
  logic [1:0]  state;
  logic        motion_tick;
  logic [3:0]  speed;
  logic [11:0] score_bcd;
  logic [1:0]  anim_phase;
  logic        game_over;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_CYCLES (TICK),
    .PASS_LIMIT  (PASS),
    .SPEED_MAX   (SMAX),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_btn     (start_btn),
    .collision     (collision),
    .obstacle_wrap (obstacle_wrap),
    .state         (state),
    .motion_tick   (motion_tick),
    .speed         (speed),
    .score_bcd     (score_bcd),
    .anim_phase    (anim_phase),
    .game_over     (game_over)
  );

  int checks = 0;
  int errors = 0;

  // Game model: 0 idle, 1 run, 2 dying, 3 over; cycles_in_run counts RUN cycles modulo TICK.
  int m_state, m_cycles_in_run, m_score, m_speed, m_pass, m_anim, m_dwell, m_tick;
  bit m_prev_start;
  int dut_ticks;

  function automatic int to_bcd(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic bit one_in(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cycles_in_run = 0; m_score = 0; m_speed = 1;
    m_pass = 0; m_anim = 0; m_dwell = 0; m_tick = 0; m_prev_start = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit w);
    bit rise;
    rise = s && !m_prev_start;
    m_prev_start = s;
    m_tick = 0;
    if (m_state == 0 || m_state == 3) begin
      if (rise) begin
        m_state = 1; m_cycles_in_run = 0; m_score = 0; m_speed = 1; m_pass = 0; m_anim = 0;
      end
    end else if (m_state == 1) begin
      if (c) begin
        m_state = 2; m_dwell = 0;
      end else begin
        if (m_cycles_in_run == TICK - 1) begin
          m_tick = 1;
          m_score = (m_score + 1) % 1000;
          m_anim = (m_anim + 1) % 4;
        end
        m_cycles_in_run = (m_cycles_in_run + 1) % TICK;
        if (w) begin
          m_pass++;
          if (m_pass == PASS) begin
            m_pass = 0;
            if (m_speed < SMAX) m_speed++;
          end
        end
      end
    end else begin
      m_dwell++;
      if (m_dwell == DEAD) m_state = 3;
    end
  endtask

  task automatic check_all();
    check("state", state, m_state);
    check("motion_tick", motion_tick, m_tick);
    check("speed", speed, m_speed);
    check("score_bcd", score_bcd, to_bcd(m_score));
    check("anim_phase", anim_phase, m_anim);
    check("game_over", game_over, (m_state == 3) ? 1 : 0);
  endtask

  task automatic cycle(input bit s, input bit c, input bit w);
    start_btn = s; collision = c; obstacle_wrap = w;
    @(posedge clk);
    #1;
    model_step(s, c, w);
    if (motion_tick === 1'b1) dut_ticks++;
    check_all();
  endtask

  initial begin
    int budget;
    int dying_len;
    int score_before;

    reset = 1'b1; start_btn = 1'b0; collision = 1'b0; obstacle_wrap = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();

    reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Start and ten ticks without obstacle wraps
    cycle(1'b1, 1'b0, 1'b0);
    check("run_after_start", state, 1);
    dut_ticks = 0;
    budget = 0;
    while (dut_ticks < 10 && budget < 200) begin
      cycle(one_in(2), 1'b0, 1'b0);
      budget++;
    end
    check("ten_ticks_seen", dut_ticks, 10);
    check("score_after_10", score_bcd, 12'h010);
    check("anim_after_10", anim_phase, 2);

    // Speed steps on every PASS wraps and saturates
    repeat (12) cycle(one_in(2), 1'b0, 1'b1);
    check("speed_after_12", speed, 2);
    repeat (11) cycle(one_in(2), 1'b0, 1'b1);
    check("speed_after_23", speed, 2);
    cycle(one_in(2), 1'b0, 1'b1);
    check("speed_after_24", speed, 3);
    repeat (200) cycle(one_in(2), 1'b0, 1'b1);
    check("speed_saturated", speed, 15);

    // Score wrap 998 -> 999 -> 000
    budget = 0;
    while (m_score != 998 && budget < 6000) begin
      cycle(one_in(2), 1'b0, one_in(3));
      budget++;
    end
    check("score_998", score_bcd, 12'h998);
    budget = 0;
    while (m_score != 999 && budget < 10) begin
      cycle(1'b0, 1'b0, 1'b0);
      budget++;
    end
    check("score_999", score_bcd, 12'h999);
    budget = 0;
    while (m_score != 0 && budget < 10) begin
      cycle(1'b0, 1'b0, 1'b0);
      budget++;
    end
    check("score_wrap_000", score_bcd, 12'h000);
    check("score_known", $isunknown(score_bcd), 0);

    // Collision in the tick cycle, start held through DYING
    budget = 0;
    while (m_cycles_in_run != TICK - 1 && budget < 10) begin
      cycle(1'b0, 1'b0, 1'b0);
      budget++;
    end
    score_before = m_score;
    cycle(1'b0, 1'b1, 1'b1);
    check("coll_no_tick", motion_tick, 0);
    check("coll_score_hold", score_bcd, to_bcd(score_before));
    check("coll_to_dying", state, 2);
    dying_len = 1;
    budget = 0;
    while (state === 2'd2 && budget < 20) begin
      cycle(1'b1, one_in(2), one_in(2));
      if (state === 2'd2) dying_len++;
      budget++;
    end
    check("dying_length", dying_len, DEAD);
    check("over_game_over", game_over, 1);
    repeat (5) cycle(1'b1, one_in(2), one_in(2));
    check("held_start_stays_over", state, 3);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("restart_run", state, 1);
    check("restart_score", score_bcd, 12'h000);
    check("restart_speed", speed, 1);

    // Random play including collisions and restarts
    repeat (600) cycle(one_in(3), one_in(24), one_in(3));

    // Reset asserted in the middle of DYING
    budget = 0;
    while (m_state != 1 && budget < 40) begin
      cycle(budget[0], 1'b0, 1'b0);
      budget++;
    end
    cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("pre_reset_dying", state, 2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    check("idle_after_reset", state, 0);

    // Start held across reset release gives an edge on the first clock
    reset = 1'b1;
    start_btn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    check("start_at_release", state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 2000000; clk cycles per motion tick.
REQ-002 Parameter PASS_LIMIT, default 12; obstacle passes per speed step.
REQ-003 Parameter SPEED_MAX, default 15; speed saturation value.
REQ-004 Parameter DEAD_CYCLES, default 50000000; dwell time in DYING.
REQ-005 clk  in  1  system clock, 50 MHz.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start_btn  in  1  replay/start button level from controller report.
REQ-008 collision  in  1  level, high while any dino/obstacle overlap exists.
REQ-009 obstacle_wrap  in  1  one-cycle pulse per obstacle wrap (at most one per cycle).
REQ-010 state  out  2  IDLE=0, RUN=1, DYING=2, OVER=3.
REQ-011 motion_tick  out  1  one-cycle pulse that advances obstacles, LFSR and animation.
REQ-012 speed  out  4  obstacle step in pixels per tick.
REQ-013 score_bcd  out  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-014 anim_phase  out  2  sprite animation phase.
REQ-015 game_over  out  1  high exactly when state==OVER.

Function
REQ-016 start_btn is registered each cycle; start_edge = start_btn & ~start_q.
REQ-017 IDLE: start_edge -> RUN next cycle; score=000, speed=1, pass_cnt=0, tick_cnt=0, anim_phase=0 on entry.
REQ-018 RUN: tick_cnt counts 0..TICK_CYCLES-1 and wraps; motion_tick=1 only in the cycle tick_cnt==TICK_CYCLES-1.
REQ-019 Each motion_tick: score_bcd +1 with per-digit carry; 999 wraps to 000; anim_phase +1 mod 4.
REQ-020 RUN, obstacle_wrap: pass_cnt +1; when the incremented value equals PASS_LIMIT, pass_cnt=0 and speed +1, saturating at SPEED_MAX.
REQ-021 RUN, collision=1: next state DYING; in that cycle motion_tick is suppressed and score, speed, pass_cnt and anim_phase hold.
REQ-022 Collision has priority over tick and obstacle_wrap in the same cycle.
REQ-023 DYING: dwell counter runs DEAD_CYCLES cycles, then OVER; motion_tick=0; start_btn is ignored; outputs frozen.
REQ-024 OVER: game_over=1, outputs frozen; start_edge -> RUN with the same initialisation as REQ-017.
REQ-025 A button held through DYING does not restart; a fresh rising edge in OVER is required.
REQ-026 motion_tick=0 in IDLE, DYING and OVER.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-028 Asynchronous reset forces state=IDLE, motion_tick=0, speed=1, score_bcd=000, anim_phase=0, game_over=0, and clears tick_cnt, pass_cnt, dwell_cnt and start_q.
REQ-029 Reset asserted mid-RUN or mid-DYING aborts immediately; no pending tick is emitted after release.
REQ-030 First start_edge is evaluated on the first clk edge after reset release; start_q=0 at release.

Structure
REQ-031 Package game_pkg holds: the state enum typedef (2 bits), SCORE_DIGITS=3, SPEED_W=4, and default constants for TICK_CYCLES, PASS_LIMIT and SPEED_MAX.
REQ-032 One sub-module, bcd_counter3: synchronous clear, increment enable, 999->000 wrap; used for the score.
REQ-033 Counter widths are derived from parameters with $clog2; no divide or modulo operators.

Verification
REQ-034 Bench parameters: TICK_CYCLES=4, DEAD_CYCLES=8, PASS_LIMIT=12.
REQ-035 Reset, then start pulse -> RUN; motion_tick every 4th cycle; after 10 ticks score_bcd=0x010 and anim_phase=2.
REQ-036 Preload score 998, run 2 ticks -> 0x999, then 0x000; no X, no carry out.
REQ-037 12 obstacle_wrap pulses -> speed=2, pass_cnt=0; 200 pulses -> speed saturates at 15.
REQ-038 Collision in the same cycle as a tick -> no tick, score unchanged, DYING for 8 cycles, then OVER with game_over=1; start held throughout -> stays OVER; release then press -> RUN with score=000 and speed=1.
REQ-039 Assert reset mid-DYING -> IDLE immediately; all outputs at reset values; no motion_tick for 20 cycles without start.
